// File: rtl/alu_seq.sv
// alu_seq: sequential RV32I execute unit with a valid/ready handshake.
//   Logical, arithmetic and compare ops complete in one cycle. Shifts run one
//   bit per cycle unless ALU_FAST_SHIFT_EN is defined, which builds a
//   single-cycle barrel shifter instead. Results are identical in both modes.
// Ports:
//   clk, rst            rising-edge clock, asynchronous active-high reset
//   in_valid / in_ready operand handshake; accept = in_valid && in_ready
//   op, a, b            operation code and operands, sampled on accept
//   out_valid/out_ready result handshake; result held until consumed
//   result              registered result
//   busy                high while an iterative shift is running
package common;
  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_SLL  = 4'd2,
    ALU_SLT  = 4'd3,
    ALU_SLTU = 4'd4,
    ALU_XOR  = 4'd5,
    ALU_SRL  = 4'd6,
    ALU_SRA  = 4'd7,
    ALU_OR   = 4'd8,
    ALU_AND  = 4'd9
  } alu_operation_type;
endpackage

module alu_seq #(
  parameter int unsigned XLEN = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  common::alu_operation_type op,
  input  logic [XLEN-1:0]          a,
  input  logic [XLEN-1:0]          b,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [XLEN-1:0]          result,
  output logic                     busy
);
  import common::*;

`ifdef ALU_FAST_SHIFT_EN
  typedef enum logic [1:0] {S_IDLE, S_DONE} state_t;
`else
  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} state_t;
`endif

  state_t          state, state_nx;
  logic [XLEN-1:0] result_nx;
  logic [XLEN-1:0] alu_res;
  logic [4:0]      shamt;

  assign shamt = b[4:0];

  // Combinational operation result for everything that finishes in one cycle.
  always_comb begin
    alu_res = '0;
    case (op)
      ALU_ADD:  alu_res = a + b;
      ALU_SUB:  alu_res = a - b;
      ALU_XOR:  alu_res = a ^ b;
      ALU_OR:   alu_res = a | b;
      ALU_AND:  alu_res = a & b;
      ALU_SLT:  alu_res = {{(XLEN-1){1'b0}}, $signed(a) < $signed(b)};
      ALU_SLTU: alu_res = {{(XLEN-1){1'b0}}, a < b};
`ifdef ALU_FAST_SHIFT_EN
      ALU_SLL:  alu_res = a << shamt;
      ALU_SRL:  alu_res = a >> shamt;
      ALU_SRA:  alu_res = XLEN'($signed(a) >>> shamt);
`endif
      default:  alu_res = '0;
    endcase
  end

`ifndef ALU_FAST_SHIFT_EN
  logic [XLEN-1:0]   acc, acc_nx, acc_sh;
  logic [4:0]        cnt, cnt_nx;
  alu_operation_type sop, sop_nx;
  logic              is_shift;

  assign is_shift = (op == ALU_SLL) || (op == ALU_SRL) || (op == ALU_SRA);

  // One-bit step of the running shift; SRA replicates the current MSB,
  // which is still the original a[31].
  always_comb begin
    case (sop)
      ALU_SLL: acc_sh = {acc[XLEN-2:0], 1'b0};
      ALU_SRA: acc_sh = {acc[XLEN-1], acc[XLEN-1:1]};
      default: acc_sh = {1'b0, acc[XLEN-1:1]};
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc <= '0;
      cnt <= '0;
      sop <= ALU_ADD;
    end else begin
      acc <= acc_nx;
      cnt <= cnt_nx;
      sop <= sop_nx;
    end
  end

  assign busy = (state == S_SHIFT);
`else
  assign busy = 1'b0;
`endif

  assign in_ready  = (state == S_IDLE) || ((state == S_DONE) && out_ready);
  assign out_valid = (state == S_DONE);

  always_comb begin
    state_nx  = state;
    result_nx = result;
`ifndef ALU_FAST_SHIFT_EN
    acc_nx    = acc;
    cnt_nx    = cnt;
    sop_nx    = sop;
`endif
    case (state)
`ifndef ALU_FAST_SHIFT_EN
      S_SHIFT: begin
        acc_nx = acc_sh;
        cnt_nx = cnt - 5'd1;
        if (cnt == 5'd1) begin
          result_nx = acc_sh;
          state_nx  = S_DONE;
        end
      end
`endif
      default: begin
        // IDLE and DONE share the accept path; a DONE-state accept with
        // out_ready high is the back-to-back case.
        if ((state == S_DONE) && out_ready) state_nx = S_IDLE;
        if (in_valid && in_ready) begin
`ifndef ALU_FAST_SHIFT_EN
          if (is_shift) begin
            if (shamt == 5'd0) begin
              result_nx = a;
              state_nx  = S_DONE;
            end else begin
              acc_nx   = a;
              cnt_nx   = shamt;
              sop_nx   = op;
              state_nx = S_SHIFT;
            end
          end else begin
            result_nx = alu_res;
            state_nx  = S_DONE;
          end
`else
          result_nx = alu_res;
          state_nx  = S_DONE;
`endif
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= S_IDLE;
      result <= '0;
    end else begin
      state  <= state_nx;
      result <= result_nx;
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: directed self-checking bench for alu_seq (iterative shift build).
// Inputs change and outputs are sampled on the falling clock edge.
module tb_alu_seq;
  import common::*;

  logic              clk = 1'b0;
  logic              rst;
  logic              in_valid;
  logic              in_ready;
  alu_operation_type op;
  logic [31:0]       a;
  logic [31:0]       b;
  logic              out_valid;
  logic              out_ready;
  logic [31:0]       result;
  logic              busy;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  alu_seq #(.XLEN(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .busy      (busy)
  );

  // Present a transaction; the caller is positioned just after a falling edge.
  task automatic send(input alu_operation_type o, input logic [31:0] x, input logic [31:0] y);
    in_valid = 1'b1;
    op       = o;
    a        = x;
    b        = y;
  endtask

  task automatic test_reset;
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    op        = ALU_ADD;
    a         = '0;
    b         = '0;
    repeat (2) @(negedge clk);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
    checks++; if (result !== 32'h0) begin errors++; $display("FAIL reset_result: got %h expected 00000000", result); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_add;
    send(ALU_ADD, 32'hFFFF_FFFF, 32'h1);
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL add_in_ready: got %b expected 1", in_ready); end
    @(negedge clk);
    in_valid = 1'b0;
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL add_out_valid: got %b expected 1", out_valid); end
    checks++; if (result !== 32'h0) begin errors++; $display("FAIL add_result: got %h expected 00000000", result); end
    @(negedge clk);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL add_valid_drop: got %b expected 0", out_valid); end
  endtask

  task automatic test_arith;
    alu_operation_type ops [5];
    logic [31:0]       av  [5];
    logic [31:0]       bv  [5];
    logic [31:0]       exp [5];
    ops[0] = ALU_SUB;  av[0] = 32'd5;         bv[0] = 32'd7;  exp[0] = 32'hFFFF_FFFE;
    ops[1] = ALU_SLT;  av[1] = 32'hFFFF_FFFE; bv[1] = 32'd1;  exp[1] = 32'd1;
    ops[2] = ALU_SLTU; av[2] = 32'hFFFF_FFFE; bv[2] = 32'd1;  exp[2] = 32'd0;
    ops[3] = ALU_SLTU; av[3] = 32'd1;         bv[3] = 32'hFFFF_FFFE; exp[3] = 32'd1;
    ops[4] = alu_operation_type'(4'hF); av[4] = 32'd5; bv[4] = 32'd7; exp[4] = 32'd0;
    for (int i = 0; i < 5; i++) begin
      send(ops[i], av[i], bv[i]);
      @(negedge clk);
      in_valid = 1'b0;
      checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL arith%0d_out_valid: got %b expected 1", i, out_valid); end
      checks++; if (result !== exp[i]) begin errors++; $display("FAIL arith%0d_result: got %h expected %h", i, result, exp[i]); end
      @(negedge clk);
    end
  endtask

  task automatic test_shift;
    alu_operation_type ops [2];
    logic [31:0]       exp [2];
    ops[0] = ALU_SRA; exp[0] = 32'hFFFF_FFFF;
    ops[1] = ALU_SRL; exp[1] = 32'h0000_0001;
    for (int s = 0; s < 2; s++) begin
      send(ops[s], 32'h8000_0000, 32'd31);
      @(negedge clk);
      // Unrelated request during the shift must be ignored.
      send(ALU_ADD, 32'd123, 32'd456);
      for (int i = 0; i < 31; i++) begin
        checks++;
        if ({busy, in_ready, out_valid} !== 3'b100) begin
          errors++;
          $display("FAIL shift%0d_busy_cycle%0d: got busy/in_ready/out_valid=%b expected 100", s, i, {busy, in_ready, out_valid});
        end
        if (i == 30) in_valid = 1'b0;
        if (i < 30) @(negedge clk);
      end
      @(negedge clk);
      checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL shift%0d_out_valid: got %b expected 1", s, out_valid); end
      checks++; if (result !== exp[s]) begin errors++; $display("FAIL shift%0d_result: got %h expected %h", s, result, exp[s]); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL shift%0d_busy_done: got %b expected 0", s, busy); end
      @(negedge clk);
    end
    send(ALU_SLL, 32'h1, 32'h0);
    @(negedge clk);
    in_valid = 1'b0;
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL sll0_out_valid: got %b expected 1", out_valid); end
    checks++; if (result !== 32'h1) begin errors++; $display("FAIL sll0_result: got %h expected 00000001", result); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL sll0_busy: got %b expected 0", busy); end
    @(negedge clk);
    send(ALU_SLL, 32'h0000_0003, 32'd4);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (4) @(negedge clk);
    checks++; if (result !== 32'h30 || out_valid !== 1'b1) begin errors++; $display("FAIL sll4_result: got %h valid %b expected 00000030 valid 1", result, out_valid); end
    @(negedge clk);
  endtask

  task automatic test_back_to_back;
    send(ALU_ADD, 32'd1, 32'd2);
    @(negedge clk);
    checks++; if (result !== 32'd3 || out_valid !== 1'b1) begin errors++; $display("FAIL b2b_add: got %h valid %b expected 00000003 valid 1", result, out_valid); end
    send(ALU_XOR, 32'hF0, 32'hFF);
    @(negedge clk);
    checks++; if (result !== 32'h0F || out_valid !== 1'b1) begin errors++; $display("FAIL b2b_xor: got %h valid %b expected 0000000f valid 1", result, out_valid); end
    send(ALU_OR, 32'h1, 32'h2);
    @(negedge clk);
    checks++; if (result !== 32'h3 || out_valid !== 1'b1) begin errors++; $display("FAIL b2b_or: got %h valid %b expected 00000003 valid 1", result, out_valid); end
    in_valid = 1'b0;
    @(negedge clk);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL b2b_drop: got %b expected 0", out_valid); end
  endtask

  task automatic test_backpressure;
    out_ready = 1'b0;
    send(ALU_AND, 32'hFF00, 32'h0FF0);
    @(negedge clk);
    // A pending request waits behind the held result.
    send(ALU_ADD, 32'd10, 32'd20);
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (out_valid !== 1'b1 || result !== 32'h0F00 || in_ready !== 1'b0) begin
        errors++;
        $display("FAIL bp_hold%0d: got valid %b result %h in_ready %b expected 1 00000f00 0", i, out_valid, result, in_ready);
      end
      if (i < 4) @(negedge clk);
    end
    out_ready = 1'b1;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_in_ready_release: got %b expected 1", in_ready); end
    @(negedge clk);
    in_valid = 1'b0;
    checks++; if (result !== 32'd30 || out_valid !== 1'b1) begin errors++; $display("FAIL bp_next: got %h valid %b expected 0000001e valid 1", result, out_valid); end
    @(negedge clk);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_drop: got %b expected 0", out_valid); end
  endtask

  task automatic test_reset_abort;
    send(ALU_SLL, 32'h1, 32'd20);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (4) @(negedge clk);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL abort_busy_before: got %b expected 1", busy); end
    rst = 1'b1;
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL abort_out_valid: got %b expected 0", out_valid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL abort_busy: got %b expected 0", busy); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL abort_in_ready: got %b expected 1", in_ready); end
    checks++; if (result !== 32'h0) begin errors++; $display("FAIL abort_result: got %h expected 00000000", result); end
    @(negedge clk);
    rst = 1'b0;
    repeat (25) @(negedge clk);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL abort_no_late_valid: got %b expected 0", out_valid); end
    send(ALU_ADD, 32'd2, 32'd2);
    @(negedge clk);
    in_valid = 1'b0;
    checks++; if (result !== 32'd4 || out_valid !== 1'b1) begin errors++; $display("FAIL abort_then_add: got %h valid %b expected 00000004 valid 1", result, out_valid); end
    @(negedge clk);
  endtask

  initial begin
    test_reset;
    test_add;
    test_arith;
    test_shift;
    test_back_to_back;
    test_backpressure;
    test_reset_abort;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
